// File: rtl/mem_stage_if.sv
// EX->MEM / MEM->WB / MEM->ID bus bundle for the memory stage.
// The master side is the surrounding pipeline (EX, SRAM, stall controller);
// the slave side is mem_stage itself.
interface mem_stage_if;
    logic [5:0]  stall;
    logic [79:0] ex_to_mem_bus;
    logic [65:0] ex_to_mem_1;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [65:0] mem_to_wb_1;
    logic [37:0] mem_to_id_bus;
    logic [65:0] mem_to_id_2;

    modport master (
        output stall, ex_to_mem_bus, ex_to_mem_1, data_sram_rdata,
        input  mem_to_wb_bus, mem_to_wb_1, mem_to_id_bus, mem_to_id_2
    );

    modport slave (
        input  stall, ex_to_mem_bus, ex_to_mem_1, data_sram_rdata,
        output mem_to_wb_bus, mem_to_wb_1, mem_to_id_bus, mem_to_id_2
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS pipeline MEM stage: registers the EX result and HI/LO request,
// extracts/extends load data from the synchronous data SRAM and keeps that
// data alive while WB is stalled (the SRAM address may move underneath us).
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    localparam logic       STOP    = 1'b1;
    localparam logic [3:0] RD_LW   = 4'b1111;
    localparam logic [3:0] RD_LB   = 4'b0001;
    localparam logic [3:0] RD_LBU  = 4'b0010;
    localparam logic [3:0] RD_LH   = 4'b0011;
    localparam logic [3:0] RD_LHU  = 4'b0100;

    logic [79:0] ex_bus_q, ex_bus_d;
    logic [65:0] hilo_q, hilo_d;
    logic [31:0] rdata_hold_q, rdata_hold_d;
    logic        hold_valid_q, hold_valid_d;

    logic        stall_mem, stall_wb, bubble, advance;
    logic [31:0] mem_pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [3:0]  data_ram_read;
    logic        is_load;
    logic [31:0] rdata_eff;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        unused_stall_bits;

    assign stall_mem = (bus.stall[3] == STOP);
    assign stall_wb  = (bus.stall[4] == STOP);
    assign bubble    = stall_mem && !stall_wb;
    // Any cycle where this stage's register changes (capture or bubble) ends
    // the current occupant's life in MEM, so its held data must go too.
    assign advance   = !stall_mem || bubble;

    // Only stall bits 3 and 4 concern this stage.
    assign unused_stall_bits = ^{bus.stall[5], bus.stall[2:0]};

    assign mem_pc        = ex_bus_q[79:48];
    assign data_ram_en   = ex_bus_q[47];
    assign data_ram_wen  = ex_bus_q[46:43];
    assign sel_rf_res    = ex_bus_q[42];
    assign rf_we         = ex_bus_q[41];
    assign rf_waddr      = ex_bus_q[40:36];
    assign ex_result     = ex_bus_q[35:4];
    assign data_ram_read = ex_bus_q[3:0];
    assign is_load       = data_ram_en && (data_ram_wen == 4'b0000);

    // Next state of the pipeline register and the SRAM read-data hold.
    always_comb begin
        ex_bus_d     = ex_bus_q;
        hilo_d       = hilo_q;
        rdata_hold_d = rdata_hold_q;
        hold_valid_d = hold_valid_q;

        if (bubble) begin
            ex_bus_d = '0;
            hilo_d   = '0;
        end else if (!stall_mem) begin
            ex_bus_d = bus.ex_to_mem_bus;
            hilo_d   = bus.ex_to_mem_1;
        end

        if (advance) begin
            hold_valid_d = 1'b0;
        end else if (is_load && stall_wb && !hold_valid_q) begin
            rdata_hold_d = bus.data_sram_rdata;
            hold_valid_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_bus_q     <= '0;
            hilo_q       <= '0;
            rdata_hold_q <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            ex_bus_q     <= ex_bus_d;
            hilo_q       <= hilo_d;
            rdata_hold_q <= rdata_hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Lane selection and extension of the load data; misalignment is ignored.
    always_comb begin
        rdata_eff = hold_valid_q ? rdata_hold_q : bus.data_sram_rdata;

        case (ex_result[1:0])
            2'd0:    byte_sel = rdata_eff[7:0];
            2'd1:    byte_sel = rdata_eff[15:8];
            2'd2:    byte_sel = rdata_eff[23:16];
            default: byte_sel = rdata_eff[31:24];
        endcase

        half_sel = ex_result[1] ? rdata_eff[31:16] : rdata_eff[15:0];

        case (data_ram_read)
            RD_LW:   load_data = rdata_eff;
            RD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            RD_LBU:  load_data = {24'd0, byte_sel};
            RD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            RD_LHU:  load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase

        rf_wdata = sel_rf_res ? load_data : ex_result;
    end

    assign bus.mem_to_wb_bus = {mem_pc, rf_we, rf_waddr, rf_wdata};
    assign bus.mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};
    assign bus.mem_to_wb_1   = hilo_q;
    assign bus.mem_to_id_2   = hilo_q;
endmodule
